arith_pipeline: RTL and testbench

//   Three-stage pipelined arithmetic datapath. Computes F = ((A + B) + (C - D)) * D
//   on unsigned N-bit operands, all results truncated modulo 2^N.

---
 rtl/arith_pipeline.sv | 87 ++++++++
 tb/tb_arith_pipeline.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/arith_pipeline.sv
// arith_pipeline: three-stage pipelined datapath computing
//   F = ((A + B) + (C - D)) * D, all arithmetic modulo 2^N.
// A new operand set is accepted every clock and its result appears on F
// three rising edges later. There is no handshake and no stall. F_valid
// marks results that come only from operands sampled after reset.
module arith_pipeline #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    output logic [N-1:0] F,
    output logic         F_valid
);

    // Stage 1 registers: partial sums, plus D carried along with its operand set
    logic [N-1:0] s1_x1_r;
    logic [N-1:0] s1_x2_r;
    logic [N-1:0] s1_d_r;

    // Stage 2 registers: combined sum, plus D still aligned with its set
    logic [N-1:0] s2_x3_r;
    logic [N-1:0] s2_d_r;

    // Stage 3 register: the result driven straight onto F
    logic [N-1:0] f_r;

    // Valid shift chain: one bit per stage, filled with 1s after reset
    logic [2:0]   valid_r;

    // Truncated product for stage 3; only the low N bits are ever kept
    logic [N-1:0] prod_s;

    // Stage 1: first add and the wrapping subtract, plus the D delay
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_x1_r <= '0;
            s1_x2_r <= '0;
            s1_d_r  <= '0;
        end else begin
            s1_x1_r <= A + B;
            s1_x2_r <= C - D;
            s1_d_r  <= D;
        end
    end

    // Stage 2: combine the two partial results and keep D aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_x3_r <= '0;
            s2_d_r  <= '0;
        end else begin
            s2_x3_r <= s1_x1_r + s1_x2_r;
            s2_d_r  <= s1_d_r;
        end
    end

    // N x N multiply whose result is kept to N bits (mod 2^N)
    always_comb begin
        prod_s = s2_x3_r * s2_d_r;
    end

    // Stage 3: register the truncated product as the output result
    always_ff @(posedge clk) begin
        if (rst) begin
            f_r <= '0;
        end else begin
            f_r <= prod_s;
        end
    end

    // Valid chain: F_valid rises on the third edge after reset release
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 3'b000;
        end else begin
            valid_r <= {valid_r[1:0], 1'b1};
        end
    end

    assign F       = f_r;
    assign F_valid = valid_r[2];

endmodule

// File: tb/tb_arith_pipeline.sv
// Self-checking bench for arith_pipeline (N = 10). Directed vectors use
// hand-computed results; the random run uses an integer reference model and
// an array of expected results delayed by the three-edge latency.
module tb_arith_pipeline;

    localparam int N = 10;

    logic         clk;
    logic         rst;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] C;
    logic [N-1:0] D;
    logic [N-1:0] F;
    logic         F_valid;

    int n_checks;
    int n_fail;

    arith_pipeline #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .F       (F),
        .F_valid (F_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-precision integer arithmetic, then reduce mod 1024
    function automatic logic [N-1:0] ref_f(input int a, input int b, input int c, input int d);
        int t;
        t = ((a + b) + (c - d)) * d;
        return t[N-1:0];
    endfunction

    task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] c, input logic [N-1:0] d);
        A = a;
        B = b;
        C = c;
        D = d;
    endtask

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(10'd555, 10'd123, 10'd77, 10'd9);
        tick();
        tick();
        tick();
        n_checks++;
        if (F !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_F: got %0d expected 0", F);
        end
        n_checks++;
        if (F_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %0b expected 0", F_valid);
        end
    endtask

    // Release reset into a stream of four sets; checks valid ramp and results
    task automatic test_stream();
        logic [N-1:0] va [4];
        logic [N-1:0] vb [4];
        logic [N-1:0] vc [4];
        logic [N-1:0] vd [4];
        logic [N-1:0] ef [4];
        va = '{10'd10, 10'd15, 10'd20, 10'd25};
        vb = '{10'd5,  10'd7,  10'd10, 10'd12};
        vc = '{10'd8,  10'd12, 10'd14, 10'd18};
        vd = '{10'd3,  10'd4,  10'd6,  10'd8};
        ef = '{10'd60, 10'd120, 10'd228, 10'd376};
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) apply(va[i], vb[i], vc[i], vd[i]);
            else       apply(10'd0, 10'd0, 10'd0, 10'd0);
            tick();
            if (i < 2) begin
                n_checks++;
                if (F_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_valid_low edge %0d: got %0b expected 0", i + 1, F_valid);
                end
                n_checks++;
                if (F !== 10'd0) begin
                    n_fail++;
                    $display("FAIL stream_pre_valid_F edge %0d: got %0d expected 0", i + 1, F);
                end
            end else begin
                n_checks++;
                if (F_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_valid_high edge %0d: got %0b expected 1", i + 1, F_valid);
                end
                n_checks++;
                if (F !== ef[i-2]) begin
                    n_fail++;
                    $display("FAIL stream_F set %0d: got %0d expected %0d", i - 2, F, ef[i-2]);
                end
            end
        end
    endtask

    // Overflow in the add, wrap to zero, and borrow in the subtract
    task automatic test_wrap();
        logic [N-1:0] va [3];
        logic [N-1:0] vb [3];
        logic [N-1:0] vc [3];
        logic [N-1:0] vd [3];
        logic [N-1:0] ef [3];
        va = '{10'd1023, 10'd100, 10'd10};
        vb = '{10'd1,    10'd100, 10'd0};
        vc = '{10'd0,    10'd100, 10'd3};
        vd = '{10'd0,    10'd10,  10'd5};
        ef = '{10'd0,    10'd852, 10'd40};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) apply(va[i], vb[i], vc[i], vd[i]);
            else       apply(10'd1, 10'd1, 10'd1, 10'd1);
            tick();
            if (i >= 2) begin
                n_checks++;
                if (F !== ef[i-2]) begin
                    n_fail++;
                    $display("FAIL wrap_F set %0d: got %0d expected %0d", i - 2, F, ef[i-2]);
                end
            end
        end
    endtask

    // One-edge reset with two sets in flight; nothing stale may surface
    task automatic test_midreset();
        apply(10'd10, 10'd5, 10'd8, 10'd3);
        tick();
        apply(10'd15, 10'd7, 10'd12, 10'd4);
        tick();
        rst = 1'b1;
        apply(10'd20, 10'd10, 10'd14, 10'd6);
        tick();
        n_checks++;
        if (F !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset_F: got %0d expected 0", F);
        end
        n_checks++;
        if (F_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_valid: got %0b expected 0", F_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // First post-release set: ((1+2)+(3-1))*1 = 5
            if (i == 0) apply(10'd1, 10'd2, 10'd3, 10'd1);
            else        apply(10'd0, 10'd0, 10'd0, 10'd0);
            tick();
            if (i < 2) begin
                n_checks++;
                if (F !== 10'd0 || F_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midreset_recover edge %0d: got F=%0d valid=%0b expected F=0 valid=0",
                             i + 1, F, F_valid);
                end
            end else begin
                n_checks++;
                if (F !== 10'd5 || F_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midreset_first edge 3: got F=%0d valid=%0b expected F=5 valid=1",
                             F, F_valid);
                end
            end
        end
    endtask

    // 1000 random sets back to back against the reference model
    task automatic test_random();
        logic [N-1:0] exp_f [1000];
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [N-1:0] rc;
        logic [N-1:0] rd;
        for (int i = 0; i < 1002; i++) begin
            if (i < 1000) begin
                ra = N'($urandom_range(0, 1023));
                rb = N'($urandom_range(0, 1023));
                rc = N'($urandom_range(0, 1023));
                rd = N'($urandom_range(0, 1023));
                exp_f[i] = ref_f(int'(ra), int'(rb), int'(rc), int'(rd));
                apply(ra, rb, rc, rd);
            end else begin
                apply(10'd0, 10'd0, 10'd0, 10'd0);
            end
            tick();
            if (i >= 2) begin
                n_checks++;
                if (F !== exp_f[i-2] || F_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL random set %0d: got F=%0d valid=%0b expected F=%0d valid=1",
                             i - 2, F, F_valid, exp_f[i-2]);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        apply(10'd0, 10'd0, 10'd0, 10'd0);
        test_reset();
        test_stream();
        test_wrap();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
